// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO port arbiters: state encoding, width helper, legal requester range.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_MIN = 2;
  localparam int unsigned NUM_REQ_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any_req
);

  always_comb begin
    int unsigned j;
    pick     = '0;
    pick_idx = '0;
    any_req  = 1'b0;
    j        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req[j]) begin
        any_req  = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port, with a stall watchdog.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wfull,
  output logic                          busy,
  output logic                          abort_err,
  output logic [$clog2(NUM_REQ)-1:0]    abort_id,
  input  logic                          clr_err
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = (STALL_LIMIT > 0) ? clog2(STALL_LIMIT + 1) : 1;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               abort_err_q, abort_err_d;
  logic [IDX_W-1:0]   abort_id_q, abort_id_d;

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic               g_valid;
  logic               g_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req_valid),
    .rr_ptr   (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      abort_err_q <= 1'b0;
      abort_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      abort_err_q <= abort_err_d;
      abort_id_q  <= abort_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    abort_err_d = abort_err_q;
    abort_id_d  = abort_id_q;
    req_ready   = '0;
    winc        = 1'b0;
    wdata       = '0;
    g_valid     = |(req_valid & grant_q);
    g_last      = |(req_last & grant_q);

    // Write data follows the locked grant; don't-care when winc is low.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    if (clr_err) abort_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (any_req) begin
          grant_d  = pick;
          gidx_d   = pick_idx;
          rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(pick_idx + 1'b1);
          state_d  = PKT;
        end
      end
      PKT: begin
        // A full FIFO freezes both the transfer and the watchdog.
        if (!wfull) begin
          req_ready = grant_q;
          winc      = g_valid;
          if (g_valid) begin
            stall_cnt_d = '0;
            if (g_last) begin
              grant_d = '0;
              state_d = IDLE;
            end
          end else if (STALL_LIMIT > 0) begin
            if (stall_cnt_q == CNT_W'(STALL_LIMIT - 1)) begin
              abort_err_d = 1'b1;
              abort_id_d  = gidx_q;
              grant_d     = '0;
              stall_cnt_d = '0;
              state_d     = IDLE;
            end else begin
              stall_cnt_d = CNT_W'(stall_cnt_q + 1'b1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign busy      = (state_q == PKT);
  assign abort_err = abort_err_q;
  assign abort_id  = abort_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table for round-robin plus directed corner sequences.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_last = '0;
  logic [31:0]   req_data = '0;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] grant;
  logic          winc;
  logic [DW-1:0] wdata;
  logic          wfull = 1'b0;
  logic          busy;
  logic          abort_err;
  logic [1:0]    abort_id;
  logic          clr_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_fifo[$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .STALL_LIMIT(15)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .grant(grant), .winc(winc),
    .wdata(wdata), .wfull(wfull), .busy(busy), .abort_err(abort_err),
    .abort_id(abort_id), .clr_err(clr_err)
  );

  always #5 w_clk = ~w_clk;

  // FIFO model: record every word the DUT writes.
  always @(posedge w_clk) begin
    if (w_rst && winc) fifo_q.push_back(wdata);
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  exp_grant;
    logic        exp_winc;
    logic [7:0]  exp_wdata;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_port(input string name, input logic [3:0] g, input logic w,
                          input logic [7:0] wd, input logic [3:0] r);
    chk({name, ".grant"}, 32'(grant), 32'(g));
    chk({name, ".winc"}, 32'(winc), 32'(w));
    chk({name, ".req_ready"}, 32'(req_ready), 32'(r));
    chk({name, ".busy"}, 32'(busy), 32'(|g));
    if (w) chk({name, ".wdata"}, 32'(wdata), 32'(wd));
  endtask

  task automatic push_exp(input logic [7:0] v);
    exp_fifo.push_back(v);
  endtask

  initial begin
    localparam logic [31:0] BASE = 32'hD0C0B0A0;
    vecs[0]  = '{4'hF, 4'h0, BASE,         4'h0, 1'b0, 8'h00, 4'h0};
    vecs[1]  = '{4'hF, 4'h0, BASE,         4'h1, 1'b1, 8'hA0, 4'h1};
    vecs[2]  = '{4'hF, 4'h1, 32'hD0C0B0A1, 4'h1, 1'b1, 8'hA1, 4'h1};
    vecs[3]  = '{4'hF, 4'h0, BASE,         4'h0, 1'b0, 8'h00, 4'h0};
    vecs[4]  = '{4'hF, 4'h0, BASE,         4'h2, 1'b1, 8'hB0, 4'h2};
    vecs[5]  = '{4'hF, 4'h2, 32'hD0C0B1A0, 4'h2, 1'b1, 8'hB1, 4'h2};
    vecs[6]  = '{4'hF, 4'h0, BASE,         4'h0, 1'b0, 8'h00, 4'h0};
    vecs[7]  = '{4'hF, 4'h0, BASE,         4'h4, 1'b1, 8'hC0, 4'h4};
    vecs[8]  = '{4'hF, 4'h4, 32'hD0C1B0A0, 4'h4, 1'b1, 8'hC1, 4'h4};
    vecs[9]  = '{4'hF, 4'h0, BASE,         4'h0, 1'b0, 8'h00, 4'h0};
    vecs[10] = '{4'hF, 4'h0, BASE,         4'h8, 1'b1, 8'hD0, 4'h8};
    vecs[11] = '{4'hF, 4'h8, 32'hD1C0B0A0, 4'h8, 1'b1, 8'hD1, 4'h8};
    vecs[12] = '{4'hF, 4'h0, BASE,         4'h0, 1'b0, 8'h00, 4'h0};
    vecs[13] = '{4'hF, 4'h1, BASE,         4'h1, 1'b1, 8'hA0, 4'h1};
    foreach (vecs[i]) if (vecs[i].exp_winc) push_exp(vecs[i].exp_wdata);

    // Reset held with every source requesting.
    req_valid = 4'hF;
    req_data  = BASE;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk); #1;
    chk_port("reset", 4'h0, 1'b0, 8'h00, 4'h0);
    chk("reset.abort_err", 32'(abort_err), 32'd0);
    chk("reset.abort_id", 32'(abort_id), 32'd0);

    // Round-robin over four 2-beat packets, then A again.
    for (int i = 0; i < 14; i++) begin
      if (i == 0) w_rst = 1'b1;
      else @(negedge w_clk);
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      req_data  = vecs[i].data;
      #1;
      chk_port($sformatf("rr[%0d]", i), vecs[i].exp_grant, vecs[i].exp_winc,
               vecs[i].exp_wdata, vecs[i].exp_ready);
    end

    // Full backpressure on source 2 during beat 2.
    @(negedge w_clk);
    req_valid = 4'h4; req_last = 4'h0; req_data = 32'h0020_0000; #1;
    chk_port("bp.idle", 4'h0, 1'b0, 8'h00, 4'h0);
    @(negedge w_clk); #1;
    chk_port("bp.beat0", 4'h4, 1'b1, 8'h20, 4'h4);
    push_exp(8'h20);
    for (int k = 0; k < 5; k++) begin
      @(negedge w_clk);
      req_data = 32'h0021_0000; wfull = 1'b1; #1;
      chk_port($sformatf("bp.full[%0d]", k), 4'h4, 1'b0, 8'h00, 4'h0);
      chk($sformatf("bp.stall_cnt[%0d]", k), 32'(dut.stall_cnt_q), 32'd0);
    end
    @(negedge w_clk);
    wfull = 1'b0; #1;
    chk_port("bp.beat1", 4'h4, 1'b1, 8'h21, 4'h4);
    push_exp(8'h21);
    @(negedge w_clk);
    req_data = 32'h0022_0000; req_last = 4'h4; #1;
    chk_port("bp.beat2", 4'h4, 1'b1, 8'h22, 4'h4);
    push_exp(8'h22);
    @(negedge w_clk);
    req_valid = 4'h0; req_last = 4'h0; #1;
    chk_port("bp.done", 4'h0, 1'b0, 8'h00, 4'h0);
    chk("bp.abort_err", 32'(abort_err), 32'd0);

    // Watchdog: source 1 stalls after one beat while source 2 waits.
    @(negedge w_clk);
    req_valid = 4'h2; req_data = 32'h0000_1100; #1;
    chk_port("wd.idle", 4'h0, 1'b0, 8'h00, 4'h0);
    @(negedge w_clk); #1;
    chk_port("wd.beat0", 4'h2, 1'b1, 8'h11, 4'h2);
    push_exp(8'h11);
    for (int k = 0; k < 15; k++) begin
      @(negedge w_clk);
      req_valid = 4'h4; req_last = 4'h4; req_data = 32'h0030_0000; #1;
      chk($sformatf("wd.stall_grant[%0d]", k), 32'(grant), 32'h2);
      chk($sformatf("wd.stall_err[%0d]", k), 32'(abort_err), 32'd0);
    end
    @(negedge w_clk); #1;
    chk("wd.abort_err", 32'(abort_err), 32'd1);
    chk("wd.abort_id", 32'(abort_id), 32'd1);
    chk_port("wd.aborted", 4'h0, 1'b0, 8'h00, 4'h0);
    @(negedge w_clk); #1;
    chk_port("wd.next", 4'h4, 1'b1, 8'h30, 4'h4);
    push_exp(8'h30);

    // Second abort (source 3) with clr_err in the same cycle: abort wins.
    @(negedge w_clk);
    req_valid = 4'h8; req_last = 4'h0; req_data = 32'h4000_0000; #1;
    chk_port("race.idle", 4'h0, 1'b0, 8'h00, 4'h0);
    @(negedge w_clk); #1;
    chk_port("race.beat0", 4'h8, 1'b1, 8'h40, 4'h8);
    push_exp(8'h40);
    for (int k = 0; k < 15; k++) begin
      @(negedge w_clk);
      req_valid = 4'h0;
      clr_err = (k == 14);
      #1;
      chk($sformatf("race.stall_grant[%0d]", k), 32'(grant), 32'h8);
    end
    @(negedge w_clk);
    clr_err = 1'b0; #1;
    chk("race.abort_err", 32'(abort_err), 32'd1);
    chk("race.abort_id", 32'(abort_id), 32'd3);
    chk("race.grant", 32'(grant), 32'h0);
    @(negedge w_clk);
    clr_err = 1'b1;
    @(negedge w_clk);
    clr_err = 1'b0; #1;
    chk("clr.abort_err", 32'(abort_err), 32'd0);

    // Reset during beat 3 of a 5-beat packet from source 0.
    @(negedge w_clk);
    req_valid = 4'h1; req_data = 32'h0000_0050; #1;
    chk_port("rst.idle", 4'h0, 1'b0, 8'h00, 4'h0);
    @(negedge w_clk); #1;
    chk_port("rst.beat0", 4'h1, 1'b1, 8'h50, 4'h1);
    push_exp(8'h50);
    @(negedge w_clk);
    req_data = 32'h0000_0051; #1;
    chk_port("rst.beat1", 4'h1, 1'b1, 8'h51, 4'h1);
    push_exp(8'h51);
    @(negedge w_clk);
    req_data = 32'h0000_0052; #1;
    w_rst = 1'b0; #1;
    chk_port("rst.mid", 4'h0, 1'b0, 8'h00, 4'h0);
    @(negedge w_clk);
    w_rst = 1'b1; req_valid = 4'h3; req_data = 32'h0000_6052; #1;
    chk_port("rst.after", 4'h0, 1'b0, 8'h00, 4'h0);
    @(negedge w_clk); #1;
    chk("rst.regrant", 32'(grant), 32'h1);
    req_valid = 4'h0;
    @(negedge w_clk); #1;

    chk("fifo.count", 32'(fifo_q.size()), 32'(exp_fifo.size()));
    for (int i = 0; i < exp_fifo.size() && i < fifo_q.size(); i++)
      chk($sformatf("fifo[%0d]", i), 32'(fifo_q[i]), 32'(exp_fifo[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the async FIFO write port (winc/wdata/wfull) between NUM_REQ packet sources.
- Grants are round-robin and locked per packet, so one source's packet is never interleaved with another's in the FIFO.
- A stall watchdog releases the grant if the granted source stops supplying beats mid-packet, so one source cannot hold the FIFO.
- Sits in the w_clk domain, directly upstream of the FIFO write controller.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: FIFO word width.
- STALL_LIMIT, 15: consecutive cycles with granted req_valid low (FIFO not full) before abort. 0 disables the watchdog.

Ports:
- w_clk  in  1  write-domain clock.
- w_rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-source beat valid.
- req_last  in  NUM_REQ  per-source last beat of packet, qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  beat accepted this cycle when req_valid & req_ready.
- grant  out  NUM_REQ  one-hot registered grant; all zero when idle.
- winc  out  1  FIFO write strobe.
- wdata  out  DATA_WIDTH  FIFO write data.
- wfull  in  1  FIFO full flag from the write controller.
- busy  out  1  high in PKT state.
- abort_err  out  1  sticky watchdog-abort flag.
- abort_id  out  $clog2(NUM_REQ)  index of the last aborted source.
- clr_err  in  1  synchronous clear of abort_err.

Behaviour:
- Reset values (w_rst low, asynchronous): state=IDLE, grant=0, rr_ptr=0, stall_cnt=0, abort_err=0, abort_id=0. Therefore winc=0 and req_ready=0.
- States: IDLE and PKT.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant one-hot for the picked source g, set rr_ptr = g+1 mod NUM_REQ, go to PKT.
  - No beat is accepted in IDLE, so arbitration costs 1 cycle.
- PKT, granted index g:
  - req_ready[g] = ~wfull, combinational. All other req_ready bits are 0.
  - winc = req_valid[g] & ~wfull. wdata = req_data[g], a combinational mux. wdata is don't-care when winc=0.
  - Beat accepted when winc=1. If req_last[g] is also high, clear grant and return to IDLE on the next edge. This gives a 1-cycle bubble before the next packet.
- Full handling:
  - While wfull=1: winc=0, req_ready=0, and stall_cnt holds (a full FIFO is not a source stall).
  - The beat is accepted on the first cycle wfull drops with req_valid[g] still high.
- Watchdog, active only when STALL_LIMIT>0:
  - In PKT, stall_cnt increments when req_valid[g]=0 and wfull=0.
  - stall_cnt clears on any accepted beat and on entry to PKT.
  - When stall_cnt reaches STALL_LIMIT: set abort_err=1, abort_id=g, clear grant, go to IDLE. The partial packet stays in the FIFO.
  - stall_cnt width is $clog2(STALL_LIMIT+1).
- Error flag:
  - clr_err clears abort_err on the next edge.
  - If an abort and clr_err occur in the same cycle, the abort wins (abort_err=1).
- Fairness:
  - The source just served has the lowest priority at the next arbitration.
  - A single requesting source is re-granted every 2nd cycle for back-to-back single-beat packets.
- Source rules:
  - Non-granted sources must hold req_valid/req_last/req_data stable until accepted.
  - Deasserting req_valid mid-packet is legal, subject to the watchdog.
- Single-beat packet (req_last on the first beat) is legal: IDLE, PKT (1 cycle), IDLE.
- Reset mid-packet: immediate return to IDLE and grant=0. The FIFO keeps any beats already written.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state encoding (IDLE=1'b0, PKT=1'b1);
  - a clog2 helper function;
  - the legal NUM_REQ range constants.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot pick, its index, any_req.
  - Reused by the read-side arbiter.

Test Plan:
- Reset: hold w_rst low with all req_valid=1 -> grant=0, winc=0, req_ready=0, abort_err=0; after release, grant=4'b0001 one cycle later.
- Round-robin: all 4 sources send 2-beat packets continuously -> grant sequence 0001,0010,0100,1000,0001; each packet takes 3 cycles (1 arb + 2 beats); FIFO receives {A0,A1,B0,B1,C0,C1,D0,D1}.
- Full backpressure: source 2 sends 3 beats with wfull=1 during beat 2 for 5 cycles -> winc=0 and req_ready[2]=0 for those 5 cycles, stall_cnt stays 0, beat 2 is written on the first cycle wfull=0, no abort.
- Watchdog: STALL_LIMIT=15, source 1 sends 1 beat with last=0 then drops req_valid -> 15 cycles later abort_err=1, abort_id=1, grant=0; a pending source 2 is granted the following cycle.
- Error clear race: clr_err pulsed in the same cycle as a second abort -> abort_err stays 1; clr_err pulsed alone -> abort_err=0 next cycle.
- Reset mid-packet: assert w_rst low during beat 3 of a 5-beat packet from source 0 -> grant=0 and winc=0 immediately; after release, arbitration restarts with rr_ptr=0.
